// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, data width and the
// register map seen by the APB UART slave that consumes this receiver.
package uart_pkg;

  localparam int          UART_DATA_W    = 8;
  localparam logic [31:0] UART_DATA_ADDR = 32'h1000_0000;
  localparam logic [31:0] UART_LSR_ADDR  = 32'h1000_0005;
  localparam logic [7:0]  UART_LSR_EMPTY = 8'h60;
  localparam logic [7:0]  UART_LSR_READY = 8'h61;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

  // Line status value the slave reports for a given data-ready condition.
  function automatic logic [7:0] lsr_value(input logic data_ready);
    if (data_ready) begin
      return UART_LSR_READY;
    end else begin
      return UART_LSR_EMPTY;
    end
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO: registered head byte (0 when empty), occupancy count,
// full/empty flags. A push into a full FIFO is accepted only when a pop
// happens in the same cycle.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [UART_DATA_W-1:0] wdata,
  input  logic                   pop,
  output logic [UART_DATA_W-1:0] head,
  output logic [CNT_W-1:0]       count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [UART_DATA_W-1:0] mem_q [DEPTH];
  logic [UART_DATA_W-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [UART_DATA_W-1:0] head_q, head_d;
  logic                   push_en_s;
  logic                   pop_en_s;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == {CNT_W{1'b0}});
  assign pop_en_s  = pop & ~empty;
  assign push_en_s = push & (~full | pop_en_s);
  assign head      = head_q;
  assign count     = count_q;

  // Next pointers, occupancy, storage and the head byte seen after this edge.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = 8'h00;
    if (push_en_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d                = wr_ptr_q + CNT_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_en_s) begin
      rd_ptr_d = rd_ptr_q + CNT_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_en_s, pop_en_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // The slot being written this cycle becomes the head only when it is
    // the one the read pointer lands on, so forward the incoming byte.
    if (count_d == {CNT_W{1'b0}}) begin
      head_d = 8'h00;
    end else if (push_en_s && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
      head_d = wdata;
    end else begin
      head_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  // FIFO state registers; contents are cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q <= {CNT_W{1'b0}};
      rd_ptr_q <= {CNT_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      head_q   <= 8'h00;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronizes rxd, deserializes LSB-first frames and
// queues non-zero bytes for the UART slave, with sticky overrun and
// framing-error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   pclk,
  input  logic                   presetn,
  input  logic                   rxd,
  input  logic                   read,
  input  logic                   err_clr,
  output logic [UART_DATA_W-1:0] char_out,
  output logic [CNT_W-1:0]       rx_count,
  output logic                   overrun,
  output logic                   frame_err
);

  localparam int            TW        = $clog2(CLK_DIV);
  localparam logic [TW-1:0] TICK_HALF = TW'(CLK_DIV / 2 - 1);
  localparam logic [TW-1:0] TICK_FULL = TW'(CLK_DIV - 1);

  logic [1:0]             sync_q, sync_d;
  rx_state_e              state_q, state_d;
  logic [2:0]             bcnt_q, bcnt_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [UART_DATA_W-1:0] shreg_q, shreg_d;
  logic                   overrun_q, overrun_d;
  logic                   frame_err_q, frame_err_d;
  logic                   rxs_s;
  logic                   tick_zero_s;
  logic                   push_req_s;
  logic                   stop_bad_s;
  logic                   pop_s;
  logic                   full_s;
  logic                   empty_s;

  assign sync_d      = {sync_q[0], rxd};
  assign rxs_s       = sync_q[1];
  assign tick_zero_s = (tick_q == {TW{1'b0}});
  assign pop_s       = read & ~empty_s;
  assign overrun     = overrun_q;
  assign frame_err   = frame_err_q;

  // Frame sequencing. IDLE is only ever entered with the line high, so a
  // low rxs seen in IDLE is always a fresh falling edge.
  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    tick_d     = tick_q;
    shreg_d    = shreg_q;
    push_req_s = 1'b0;
    stop_bad_s = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rxs_s) begin
          tick_d  = TICK_HALF;
          state_d = RX_START;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (tick_zero_s) begin
          if (rxs_s) begin
            state_d = RX_IDLE;
          end else begin
            tick_d  = TICK_FULL;
            bcnt_d  = 3'd0;
            state_d = RX_DATA;
          end
        end else begin
          tick_d = tick_q - TW'(1);
        end
      end
      RX_DATA: begin
        if (tick_zero_s) begin
          shreg_d[bcnt_q] = rxs_s;
          tick_d          = TICK_FULL;
          if (bcnt_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bcnt_d = bcnt_q + 3'd1;
          end
        end else begin
          tick_d = tick_q - TW'(1);
        end
      end
      RX_STOP: begin
        if (tick_zero_s) begin
          if (rxs_s) begin
            // Zero is the empty marker on char_out, so it is never queued.
            push_req_s = (shreg_q != 8'h00);
            state_d    = RX_IDLE;
          end else begin
            stop_bad_s = 1'b1;
            state_d    = RX_BREAK;
          end
        end else begin
          tick_d = tick_q - TW'(1);
        end
      end
      RX_BREAK: begin
        if (rxs_s) begin
          state_d = RX_IDLE;
        end else begin
          state_d = RX_BREAK;
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  // Sticky error flags: a new error in the same cycle beats err_clr.
  always_comb begin
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (push_req_s && full_s && !pop_s) begin
      overrun_d = 1'b1;
    end else if (err_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
    if (stop_bad_s) begin
      frame_err_d = 1'b1;
    end else if (err_clr) begin
      frame_err_d = 1'b0;
    end else begin
      frame_err_d = frame_err_q;
    end
  end

  // Synchronizer, FSM and flag registers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sync_q      <= 2'b11;
      state_q     <= RX_IDLE;
      bcnt_q      <= 3'd0;
      tick_q      <= {TW{1'b0}};
      shreg_q     <= 8'h00;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      tick_q      <= tick_d;
      shreg_q     <= shreg_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (pclk),
    .rst_n (presetn),
    .push  (push_req_s),
    .wdata (shreg_q),
    .pop   (pop_s),
    .head  (char_out),
    .count (rx_count),
    .full  (full_s),
    .empty (empty_s)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a byte scoreboard modelling the FIFO.
module tb_uart_rx;

  localparam int CLK_DIV = 16;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 3;

  logic             pclk    = 1'b0;
  logic             presetn = 1'b0;
  logic             rxd     = 1'b1;
  logic             read    = 1'b0;
  logic             err_clr = 1'b0;
  logic [7:0]       char_out;
  logic [CNT_W-1:0] rx_count;
  logic             overrun;
  logic             frame_err;

  logic [7:0] sb_q[$];
  logic       exp_ovr  = 1'b0;
  logic       exp_ferr = 1'b0;
  int         checks   = 0;
  int         errors   = 0;
  bit         lat_chk  = 1'b0;
  bit         rd_hook  = 1'b0;

  uart_rx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .rxd       (rxd),
    .read      (read),
    .err_clr   (err_clr),
    .char_out  (char_out),
    .rx_count  (rx_count),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_head();
    if (sb_q.size() > 0) return sb_q[0];
    else return 8'h00;
  endfunction

  // Reference push rules: zero dropped, full FIFO sets overrun.
  task automatic model_push(input logic [7:0] b);
    if (b == 8'h00) begin
    end else if (sb_q.size() == DEPTH) begin
      exp_ovr = 1'b1;
    end else begin
      sb_q.push_back(b);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_char"}, char_out, exp_head());
    chk({tag, "_cnt"}, rx_count, sb_q.size());
    chk({tag, "_ovr"}, overrun, exp_ovr);
    chk({tag, "_ferr"}, frame_err, exp_ferr);
  endtask

  // Drive one 8N1 frame; called #1 after a rising edge, returns likewise.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    int e;
    bits = {stop_bit, b, 1'b0};
    e = 0;
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      for (int k = 0; k < CLK_DIV; k++) begin
        @(posedge pclk);
        #1;
        e++;
        if (lat_chk && e == 154) chk("lat_before", char_out, 8'h00);
        if (lat_chk && e == 155) begin
          chk("lat_char", char_out, 8'h41);
          chk("lat_cnt", rx_count, 1);
        end
        if (rd_hook && e == 154) begin
          chk("pp_head", char_out, exp_head());
          read = 1'b1;
        end
        if (rd_hook && e == 155) read = 1'b0;
      end
    end
    rxd = 1'b1;
  endtask

  task automatic do_read();
    chk("rd_head", char_out, exp_head());
    read = 1'b1;
    @(posedge pclk);
    #1;
    read = 1'b0;
    if (sb_q.size() > 0) void'(sb_q.pop_front());
    chk("rd_next_char", char_out, exp_head());
    chk("rd_next_cnt", rx_count, sb_q.size());
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(posedge pclk);
    #1;
    err_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  initial begin
    // Reset values
    idle(3);
    check_state("reset");
    presetn = 1'b1;
    idle(5);

    // Single byte with exact latency, then pop
    lat_chk = 1'b1;
    send_frame(8'h41, 1'b1);
    lat_chk = 1'b0;
    model_push(8'h41);
    check_state("single");
    do_read();

    // Short low glitch, then a zero byte
    rxd = 1'b0;
    idle(3);
    rxd = 1'b1;
    idle(40);
    check_state("glitch");
    send_frame(8'h00, 1'b1);
    model_push(8'h00);
    idle(5);
    check_state("zero");

    // Overrun with depth 4
    for (int i = 0; i < 5; i++) begin
      send_frame(8'h31 + 8'(i), 1'b1);
      model_push(8'h31 + 8'(i));
    end
    check_state("ovr_full");
    for (int i = 0; i < 4; i++) do_read();
    pulse_err_clr();
    exp_ovr = 1'b0;
    check_state("ovr_clr");

    // Framing error followed by a long break
    send_frame(8'h55, 1'b0);
    exp_ferr = 1'b1;
    check_state("ferr");
    rxd = 1'b0;
    idle(20 * CLK_DIV);
    pulse_err_clr();
    exp_ferr = 1'b0;
    idle(20 * CLK_DIV);
    check_state("break_once");
    rxd = 1'b1;
    idle(20);
    send_frame(8'h66, 1'b1);
    model_push(8'h66);
    check_state("after_break");
    do_read();

    // Full FIFO with a pop in the stop-sample cycle
    for (int i = 0; i < 4; i++) begin
      send_frame(8'hA1 + 8'(i), 1'b1);
      model_push(8'hA1 + 8'(i));
    end
    rd_hook = 1'b1;
    send_frame(8'hA5, 1'b1);
    rd_hook = 1'b0;
    void'(sb_q.pop_front());
    model_push(8'hA5);
    check_state("pushpop");
    for (int i = 0; i < 4; i++) do_read();

    // Reset in the middle of a frame with bytes queued
    send_frame(8'h11, 1'b1);
    model_push(8'h11);
    send_frame(8'h22, 1'b1);
    model_push(8'h22);
    check_state("pre_rst");
    rxd = 1'b0;
    idle(40);
    presetn = 1'b0;
    rxd = 1'b1;
    idle(2);
    sb_q.delete();
    exp_ovr  = 1'b0;
    exp_ferr = 1'b0;
    check_state("mid_rst");
    presetn = 1'b1;
    idle(10);
    send_frame(8'h7E, 1'b1);
    model_push(8'h7E);
    check_state("post_rst");
    do_read();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial 8N1 receiver and receive buffer that feeds the APB UART slave's `char_in`/`read` pair. It oversamples the `rxd` pin on `pclk`, deserializes frames LSB-first, and queues bytes in a small FIFO. The FIFO head is presented as `char_out`, with `0x00` meaning "no data", and is popped by the slave's one-cycle `read` pulse. It sits between the board pin and the UART slave, with no bus interface of its own.

## Interface
- `CLK_DIV`, default 16: `pclk` cycles per bit; even, ≥4.
- `FIFO_DEPTH`, default 16: entries; power of 2, ≥2.
- `CNT_W`, default $clog2(FIFO_DEPTH)+1: width of `rx_count`.
- `pclk`, in, 1: sole clock; all logic on its rising edge.
- `presetn`, in, 1: reset, asynchronous, active-low.
- `rxd`, in, 1: serial line, idle high, asynchronous to `pclk`.
- `read`, in, 1: pop request, one-cycle pulse from the UART slave.
- `err_clr`, in, 1: clears both sticky error flags.
- `char_out`, out, 8: FIFO head byte; 0 when empty.
- `rx_count`, out, `CNT_W`: current FIFO occupancy.
- `overrun`, out, 1: sticky; a good byte arrived while the FIFO was full.
- `frame_err`, out, 1: sticky; stop bit sampled low.

## Operation
- `rxd` passes through a 2-flop synchronizer, both flops reset to 1. All FSM logic uses the synchronized value `rxs`.
- FSM states: IDLE, START, DATA, STOP, BREAK. A bit counter `bcnt` (0..7) and a down-counter `tick` (`$clog2(CLK_DIV)` bits) drive the sequencing.
  - **IDLE**: when `rxs` goes 1→0 (falling edge), load `tick` = `CLK_DIV/2-1` and go to START.
  - **START**: at `tick`==0, sample `rxs`. If 1, it is a glitch: return to IDLE with no error. If 0, load `tick` = `CLK_DIV-1`, clear `bcnt`, and go to DATA.
  - **DATA**: at `tick`==0, shift `rxs` into bit `bcnt` (LSB first) and reload `tick`. After `bcnt`==7, go to STOP.
  - **STOP**: at `tick`==0, sample `rxs`.
    - If 1: push the byte, then go to IDLE.
    - If 0: set `frame_err`, discard the byte, go to BREAK.
  - **BREAK**: wait for `rxs`==1, then go to IDLE. A long low line therefore yields exactly one `frame_err` per break.
- Push rules:
  - A received byte `0x00` is dropped silently. It is not pushed and raises no flag, because 0 is the empty marker.
  - Push into a full FIFO: the byte is discarded, `overrun` is set, and stored contents are untouched.
- Pop rules:
  - `read` with a non-empty FIFO advances the read pointer.
  - `read` with an empty FIFO is ignored.
- Simultaneous push and pop:
  - Both take effect in the same cycle, including when the FIFO is full. The full case does not set `overrun`.
  - `rx_count` is unchanged.
- Pointers are `CNT_W` bits wide with natural wrap-around. Full is `rx_count`==`FIFO_DEPTH`; empty is `rx_count`==0.
- `err_clr` clears both sticky flags. If a new error occurs in the same cycle, set wins.
- Asserting `presetn` mid-frame aborts the frame. FIFO contents are lost and the FSM returns to IDLE.

## Timing
- Reset values:
  - `char_out`=0, `rx_count`=0, `overrun`=0, `frame_err`=0.
  - FSM in IDLE, `bcnt`=0, `tick`=0, pointers=0, synchronizer flops=1.
- Synchronizer latency: 2 cycles from a `rxd` change to `rxs`.
- `char_out` and `rx_count` are registered. They reflect a push or pop one cycle after it occurs.
- `char_out` stays stable through the cycle in which `read` is high. The slave samples it combinationally during the access, and `read` follows one cycle later.
- End-to-end latency: the stop-bit sample falls at 2 + `CLK_DIV/2` + 9·`CLK_DIV` cycles after the `rxd` falling edge. The byte is visible on `char_out` 1 cycle later when the FIFO was previously empty.
- Back-to-back frames are supported: IDLE accepts a new start edge in the cycle after the STOP sample.

## Structure
- The shared package `uart_pkg` holds:
  - the FSM state encoding;
  - the `UART_DATA_W`=8 constant;
  - the UART register map: data at `0x10000000`, line status at `0x10000005`, LSR values `0x60` (empty) and `0x61` (data ready).
- One sub-module, `uart_rx_fifo`: synchronous FIFO with push/pop, registered head output, occupancy, and full/empty flags. The FSM and synchronizer stay in `uart_rx`.

## Test plan
- **Single byte**: `CLK_DIV`=16, drive frame 0x41 → `char_out`=0x41 and `rx_count`=1 at cycle 2+8+144+1. Pulse `read` → `char_out`=0, `rx_count`=0 the next cycle.
- **Glitch and zero byte**:
  - A 3-cycle low glitch on `rxd` → FSM returns to IDLE, nothing pushed, no flags.
  - Frame 0x00 → `rx_count` stays 0.
- **Overrun**: `FIFO_DEPTH`=4, send 0x31..0x35 without reads → `rx_count`=4, `overrun`=1, and reading returns 0x31..0x34 in order. Then `err_clr` → `overrun`=0.
- **Frame error and break**: frame 0x55 with its stop bit held low, then `rxd` low for 40 bits → `frame_err`=1 once, nothing pushed. After `rxd` returns high, frame 0x66 is received correctly.
- **Full FIFO with push and pop together**: full FIFO, `read` pulse in the same cycle as a stop-bit push → `rx_count` stays 4, `overrun`=0, and the new byte is last in order.
- **Reset mid-frame**: assert `presetn` low during DATA with 2 bytes queued → all outputs return to reset values. The next clean frame 0x7E is received normally.
